led_sweep_gen: RTL and testbench

Parametrised LED sweep generator for DE2-115 demo boards. It drives an N-wide LED bank with one of four run-time-selectable patterns: bounce, rotate, bar fill, and a comet with a PWM-faded trail. Step rate comes from a 2-bit speed input, and the block supports pause and a position/end-of-sweep status interface. It sits directly between the board switches and `LEDR` in the demo top level.

---
 rtl/led_sweep_gen.sv | 148 ++++++++++++++
 tb/tb_led_sweep_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_gen.sv
// rtl/led_sweep_gen.sv - LED sweep generator: bounce, rotate, bar and PWM-trailed comet patterns
// Registered LEDR/POS/END_PULSE are decoded from the sweep state one cycle after it updates.
module led_sweep_gen #(
  parameter int N_LEDS   = 18,
  parameter int BASE_DIV = 5_000_000,
  parameter int TRAIL    = 3,
  parameter int PWM_BITS = 4
) (
  input  logic                            CLOCK_50,
  input  logic                            RESET,
  input  logic [1:0]                      MODE,
  input  logic [1:0]                      SPEED,
  input  logic                            PAUSE,
  output logic [N_LEDS-1:0]               LEDR,
  output logic [$clog2(N_LEDS+1)-1:0]     POS,
  output logic                            END_PULSE
);

  localparam int CW = $clog2(4 * BASE_DIV);
  localparam int PW = $clog2(N_LEDS + 1);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_COMET  = 2'd3
  } mode_e;

  mode_e                mode_q;
  logic [CW-1:0]        cnt_q, cnt_d, period_m1;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic [PWM_BITS-1:0]  pwm_q;
  logic                 mode_chg, step, at_end;
  logic                 end_stage_q, end_q;
  logic [N_LEDS-1:0]    led_d, led_q;
  logic [PW-1:0]        pos_out_q;

  always_comb begin
    mode_chg  = (MODE != mode_q);
    period_m1 = CW'(BASE_DIV * (4 - int'(SPEED)) - 1);
    // >= also catches a counter left beyond a newly shortened period
    step      = !mode_chg && !PAUSE && (cnt_q >= period_m1);
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    at_end    = 1'b0;
    if (mode_chg) begin
      cnt_d = '0;
      pos_d = '0;
      dir_d = 1'b0;
    end else if (!PAUSE) begin
      cnt_d = step ? '0 : cnt_q + CW'(1);
      if (step) begin
        case (mode_q)
          MODE_ROTATE: begin
            dir_d = 1'b0;
            if (pos_q == PW'(N_LEDS - 1)) begin
              pos_d  = '0;
              at_end = 1'b1;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end
          MODE_BAR: begin
            if (!dir_q) begin
              pos_d = pos_q + PW'(1);
              if (pos_q == PW'(N_LEDS - 1)) begin
                dir_d  = 1'b1;
                at_end = 1'b1;
              end
            end else begin
              pos_d = pos_q - PW'(1);
              if (pos_q == PW'(1)) begin
                dir_d  = 1'b0;
                at_end = 1'b1;
              end
            end
          end
          default: begin
            if (!dir_q) begin
              pos_d = pos_q + PW'(1);
              if (pos_q == PW'(N_LEDS - 2)) begin
                dir_d  = 1'b1;
                at_end = 1'b1;
              end
            end else begin
              pos_d = pos_q - PW'(1);
              if (pos_q == PW'(1)) begin
                dir_d  = 1'b0;
                at_end = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // Trail LEDs sit behind the head; anything off the end of the bank simply isn't lit
  always_comb begin
    led_d = '0;
    if (mode_q == MODE_BAR) begin
      for (int i = 0; i < N_LEDS; i++) led_d[i] = (i < int'(pos_q));
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (i == int'(pos_q)) begin
          led_d[i] = 1'b1;
        end else if (mode_q == MODE_COMET) begin
          for (int k = 1; k <= TRAIL; k++) begin
            if (((dir_q && i == int'(pos_q) + k) || (!dir_q && i + k == int'(pos_q))) &&
                int'(pwm_q) < ((2 ** PWM_BITS) >> k))
              led_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_q      <= mode_e'(MODE);
      cnt_q       <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      pwm_q       <= '0;
      end_stage_q <= 1'b0;
      end_q       <= 1'b0;
      led_q       <= '0;
      pos_out_q   <= '0;
    end else begin
      mode_q      <= mode_e'(MODE);
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      pwm_q       <= pwm_q + PWM_BITS'(1);
      end_stage_q <= at_end;
      end_q       <= end_stage_q;
      led_q       <= led_d;
      pos_out_q   <= pos_q;
    end
  end

  assign LEDR      = led_q;
  assign POS       = pos_out_q;
  assign END_PULSE = end_q;

endmodule

// File: tb/tb_led_sweep_gen.sv
// tb/tb_led_sweep_gen.sv - self-checking bench for led_sweep_gen with a step-count reference model
module tb_led_sweep_gen;
  localparam int NL = 8;
  localparam int BD = 4;
  localparam int TR = 2;
  localparam int PB = 3;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [7:0] ledr;
  logic [3:0] pos;
  logic       end_pulse;

  int checks = 0;
  int errors = 0;

  led_sweep_gen #(.N_LEDS(NL), .BASE_DIV(BD), .TRAIL(TR), .PWM_BITS(PB)) dut (
    .CLOCK_50 (clk),
    .RESET    (reset),
    .MODE     (mode),
    .SPEED    (speed),
    .PAUSE    (pause),
    .LEDR     (ledr),
    .POS      (pos),
    .END_PULSE(end_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sweep position as a closed-form function of steps taken since restart
  function automatic int mpos(input int md, input int s);
    int p;
    if (md == 1) return s % NL;
    if (md == 2) begin
      p = s % (2 * NL);
      return (p <= NL) ? p : 2 * NL - p;
    end
    p = s % (2 * NL - 2);
    return (p <= NL - 1) ? p : 2 * NL - 2 - p;
  endfunction

  function automatic bit mdir(input int md, input int s);
    if (md == 1) return 1'b0;
    if (md == 2) return (s % (2 * NL)) >= NL;
    return (s % (2 * NL - 2)) >= NL - 1;
  endfunction

  function automatic bit mend(input int md, input int s);
    int p;
    p = mpos(md, s);
    if (md == 1) return p == 0;
    if (md == 2) return p == 0 || p == NL;
    return p == 0 || p == NL - 1;
  endfunction

  function automatic logic [7:0] mled(input int md, input int s, input int pwm);
    int p, t, v;
    p = mpos(md, s);
    if (md == 2) return 8'((1 << p) - 1);
    v = 1 << p;
    if (md == 3) begin
      for (int k = 1; k <= TR; k++) begin
        t = mdir(md, s) ? p + k : p - k;
        if (t >= 0 && t < NL && pwm < ((1 << PB) >> k)) v = v | (1 << t);
      end
    end
    return 8'(v);
  endfunction

  int         m_s, m_cnt, m_pwm, m_mode;
  bit         m_end_pend, m_valid;
  logic [7:0] e_led;
  int         e_pos;
  bit         e_end;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      e_led = 8'h00; e_pos = 0; e_end = 1'b0;
      m_s = 0; m_cnt = 0; m_pwm = 0; m_mode = int'(mode); m_end_pend = 1'b0;
    end else begin
      e_led = mled(m_mode, m_s, m_pwm);
      e_pos = mpos(m_mode, m_s);
      e_end = m_end_pend;
      m_end_pend = 1'b0;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_s = 0; m_cnt = 0;
      end else if (!pause) begin
        if (m_cnt >= BD * (4 - int'(speed)) - 1) begin
          m_s++; m_cnt = 0; m_end_pend = mend(m_mode, m_s);
        end else begin
          m_cnt++;
        end
      end
      m_pwm = (m_pwm + 1) % (1 << PB);
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ledr", int'(ledr), int'(e_led));
      check("model_pos", int'(pos), e_pos);
      check("model_end", int'(end_pulse), int'(e_end));
    end
  end

  task automatic wait_pos_change(output int cyc);
    logic [3:0] prev;
    prev = pos;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (pos == prev && cyc < 100);
    check("pos_change_timeout", int'(cyc >= 100), 0);
  endtask

  task automatic wait_pos_value(input int v);
    int cyc;
    cyc = 0;
    while (int'(pos) != v && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("pos_value_timeout", int'(cyc >= 200), 0);
  endtask

  logic [7:0] bounce_tbl [14];
  logic [7:0] prev_led, others;
  int c, c2, c3, c4, cyc;

  initial begin
    bounce_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    reset = 1'b1; mode = 2'd0; speed = 2'd3; pause = 1'b0;
    @(negedge clk);
    check("reset_ledr", int'(ledr), 0);
    check("reset_pos", int'(pos), 0);
    check("reset_end", int'(end_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_ledr", int'(ledr), 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      check("bounce_ledr", int'(ledr), int'(bounce_tbl[i]));
      check("bounce_end", int'(end_pulse), int'(i == 6 || i == 13));
      repeat (4) @(negedge clk);
    end

    speed = 2'd0;
    wait_pos_change(c);
    wait_pos_change(c2);
    check("slow_period", c2, 16);
    repeat (9) @(negedge clk);
    speed = 2'd3;
    wait_pos_change(c3);
    check("speed_up_step", c3, 2);
    wait_pos_change(c4);
    check("fast_period", c4, 4);

    mode = 2'd1;
    repeat (3) @(negedge clk);
    cyc = 0;
    prev_led = ledr;
    do begin
      prev_led = ledr;
      @(negedge clk);
      cyc++;
    end while (!end_pulse && cyc < 100);
    check("rotate_end_timeout", int'(cyc >= 100), 0);
    check("rotate_wrap_ledr", int'(ledr), 1);
    check("rotate_wrap_prev", int'(prev_led), 8'h80);

    mode = 2'd2;
    repeat (3) @(negedge clk);
    check("bar_start", int'(ledr), 0);
    wait_pos_value(8);
    check("bar_full", int'(ledr), 8'hFF);
    check("bar_top_end", int'(end_pulse), 1);

    mode = 2'd3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("comet_pos0", int'(ledr), 1);
      @(negedge clk);
    end
    wait_pos_value(4);
    pause = 1'b1;
    c2 = 0; c3 = 0; c4 = 0; others = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c4 += int'(ledr[4]); c3 += int'(ledr[3]); c2 += int'(ledr[2]);
      others = others | (ledr & 8'hE3);
    end
    check("comet_head", c4, 8);
    check("comet_trail1", c3, 4);
    check("comet_trail2", c2, 2);
    check("comet_others", int'(others), 0);
    repeat (42) @(negedge clk);
    check("pause_pos", int'(pos), 4);
    pause = 1'b0;
    wait_pos_change(c);
    check("pause_resume", c, 4);

    pause = 1'b1;
    repeat (2) @(negedge clk);
    mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("paused_mode_end", int'(end_pulse), 0);
    end
    check("paused_mode_pos", int'(pos), 0);
    check("paused_mode_ledr", int'(ledr), 1);
    pause = 1'b0;

    mode = 2'd3;
    repeat (2) @(negedge clk);
    wait_pos_value(5);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ledr", int'(ledr), 0);
    check("midreset_pos", int'(pos), 0);
    check("midreset_end", int'(end_pulse), 0);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_restart", int'(ledr), 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
    end
    reset = 1'b0;
    pause = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
